// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared arbiter types, sizes and the round-robin search helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    start);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = start + ID_W'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decoder2_4.sv
// ============================================================================
// Module      : decoder2_4
// Description : 2-to-4 one-hot decoder with enable; all-zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder2_4 (
    input  logic       en_i,
    input  logic [1:0] sel_i,
    output logic [3:0] dec_o
);

    always_comb begin
        dec_o = 4'b0000;
        if (en_i) begin
            dec_o[sel_i] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_arb4_ctrl.sv
// ============================================================================
// Module      : rr_arb4_ctrl
// Description : 4-way round-robin arbiter with hold-until-release ownership and
//               direct handoff. Define RR_TIMEOUT_EN to add a hold-time limit
//               of HOLD_MAX cycles that preempts the owner when others wait.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb4_ctrl
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               preempt
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;

    logic [ID_W-1:0]    w_next_ptr;
    logic [NUM_REQ-1:0] w_others;
    logic [ID_W:0]      w_pick_idle;
    logic [ID_W:0]      w_pick_next;

    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("HOLD_MAX must be at least 1");
    end

    assign w_next_ptr  = id_q + 2'd1;
    assign w_others    = req & ~(4'b0001 << id_q);
    assign w_pick_idle = rr_pick(req, ptr_q);
    assign w_pick_next = rr_pick(w_others, w_next_ptr);

`ifdef RR_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             preempt_q, preempt_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
`ifdef RR_TIMEOUT_EN
        count_d   = count_q;
        preempt_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_pick_idle[ID_W]) begin
                    state_d = ST_OWNED;
                    id_d    = w_pick_idle[ID_W-1:0];
`ifdef RR_TIMEOUT_EN
                    count_d = CNT_W'(1);
`endif
                end
            end
            ST_OWNED: begin
                if (!req[id_q]) begin
                    ptr_d = w_next_ptr;
                    if (w_pick_next[ID_W]) begin
                        id_d = w_pick_next[ID_W-1:0];
`ifdef RR_TIMEOUT_EN
                        count_d = CNT_W'(1);
`endif
                    end else begin
                        state_d = ST_IDLE;
                        id_d    = '0;
                    end
                end
`ifdef RR_TIMEOUT_EN
                // At the limit a lone owner keeps the grant and the count saturates.
                else if (count_q == CNT_W'(HOLD_MAX)) begin
                    if (w_pick_next[ID_W]) begin
                        ptr_d     = w_next_ptr;
                        id_d      = w_pick_next[ID_W-1:0];
                        count_d   = CNT_W'(1);
                        preempt_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                id_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
        end
    end

`ifdef RR_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            preempt_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            preempt_q <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    assign gnt_valid = (state_q == ST_OWNED);
    assign gnt_id    = id_q;

    decoder2_4 u_gnt_dec (
        .en_i  (gnt_valid),
        .sel_i (id_q),
        .dec_o (gnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_rr_arb4_ctrl.sv
// ============================================================================
// Module      : tb_rr_arb4_ctrl
// Description : Directed self-checking bench for rr_arb4_ctrl (HOLD_MAX = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arb4_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int total = 0;
    int bad   = 0;

    rr_arb4_ctrl #(.HOLD_MAX(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and confirm gnt is never multi-hot.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                           input logic exp_valid);
        chk(tag, 32'(gnt), 32'(exp_gnt));
        chk({tag, "_id"}, 32'(gnt_id), 32'(exp_id));
        chk({tag, "_valid"}, 32'(gnt_valid), 32'(exp_valid));
    endtask

    initial begin
        logic [3:0] one;
        int         pre_cnt;
        rst_n = 1'b0;
        req   = 4'b0000;
        #2;
        chk_gnt("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset_preempt", 32'(preempt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single request: visible one edge after it is sampled.
        req = 4'b0100;
        #1;
        chk_gnt("single_pre", 4'b0000, 2'd0, 1'b0);
        tick();
        chk_gnt("single", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        tick();
        chk_gnt("release", 4'b0000, 2'd0, 1'b0);

        // ptr now 3: search 3,0,1 wraps to requester 1.
        req = 4'b0010;
        tick();
        chk_gnt("wrap", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        tick();
        chk_gnt("wrap_rel", 4'b0000, 2'd0, 1'b0);

        // ptr now 2: a lone requester 3 wins, then async reset mid-ownership.
        req = 4'b1000;
        tick();
        chk_gnt("own3", 4'b1000, 2'd3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_gnt("async_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b1001;
        #1;
        rst_n = 1'b1;
        tick();
        chk_gnt("post_rst", 4'b0001, 2'd0, 1'b1);

        // Round robin with direct handoff: 0,1,2,3,0.
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            one = 4'b0001 << i;
            chk("rr_hold_a", 32'(gnt), 32'(one));
            tick();
            chk("rr_hold_b", 32'(gnt), 32'(one));
            tick();
            chk("rr_hold_c", 32'(gnt), 32'(one));
            req = 4'b1111 & ~one;
            tick();
            req = 4'b1111;
            chk("rr_valid", 32'(gnt_valid), 32'd1);
            chk("rr_id", 32'(gnt_id), 32'((i + 1) % 4));
        end
        chk("rr_wrap", 32'(gnt), 32'h1);

        // Hold-time behaviour with two contending requesters from ptr = 0.
        req = 4'b0000;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 4'b0011;
        tick();
        chk_gnt("to_own0", 4'b0001, 2'd0, 1'b1);
        pre_cnt = 0;
`ifdef RR_TIMEOUT_EN
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("to_hold", 32'(gnt), 32'h1);
            chk("to_nopre", 32'(preempt), 32'd0);
        end
        tick();
        chk_gnt("to_handoff", 4'b0010, 2'd1, 1'b1);
        chk("to_preempt", 32'(preempt), 32'd1);
        for (int c = 0; c < 2; c++) begin
            tick();
            if (preempt) pre_cnt++;
        end
        chk("to_pulse_once", 32'(pre_cnt), 32'd0);
        chk("to_after", 32'(gnt), 32'h2);
`else
        for (int c = 0; c < 12; c++) begin
            tick();
            if (preempt || gnt != 4'b0001) pre_cnt++;
        end
        chk("no_timeout", 32'(pre_cnt), 32'd0);
        chk("no_timeout_gnt", 32'(gnt), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/rr_arb4_ctrl.md
RR_ARB4_CTRL -- requirements
Module: rr_arb4_ctrl

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15, meaning the maximum number of consecutive grant cycles per owner; it is used only with RR_TIMEOUT_EN.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 4 bits: request per requester, held high for the whole resource use.
REQ-005 SHALL have port gnt, output, 4 bits: registered grant, one-hot or all-zero.
REQ-006 SHALL have port gnt_id, output, 2 bits: binary index of the current owner; 0 when gnt_valid is low.
REQ-007 SHALL have port gnt_valid, output, 1 bit: high while a grant is held.
REQ-008 SHALL have port preempt, output, 1 bit: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-009 SHALL implement a two-state machine: IDLE (no owner) and OWNED (one owner).
REQ-010 SHALL, in IDLE with req != 0, select the first set req bit searching upward from ptr with wrap-around (ptr, ptr+1, ... mod 4), enter OWNED, and assert gnt on the next edge (latency 1 cycle).
REQ-011 SHALL, in IDLE with req == 0, stay in IDLE with gnt = 0.
REQ-012 SHALL, in OWNED while req[owner] is high, hold gnt, gnt_id and the owner unchanged, ignoring all other req bits.
REQ-013 SHALL, in OWNED when req[owner] falls, set ptr = owner+1 mod 4 and, on the same edge, grant the next requester per REQ-010 search excluding the old owner (direct handoff, no dead cycle), or return to IDLE if none is pending.
REQ-014 SHALL never assert more than one gnt bit in any cycle, including during handoff.
REQ-015 SHALL derive gnt from the registered gnt_id and gnt_valid through a 2-to-4 one-hot decode, so gnt and gnt_id are always consistent.
REQ-016 SHALL treat req changes on non-owner lines as having no effect until the next arbitration point.
REQ-017 SHALL hold ptr at its current value when a timeout revocation finds no other requester (see REQ-022).

Reset
REQ-018 SHALL, while rst_n is low, force state = IDLE, ptr = 0, gnt = 4'b0000, gnt_id = 0, gnt_valid = 0, preempt = 0 and hold count = 0, independent of clk.
REQ-019 SHALL drop any grant immediately on rst_n assertion mid-ownership, and arbitrate from ptr = 0 on the first edge after release.

Configuration
REQ-020 SHALL compile the hold-timeout feature only when macro RR_TIMEOUT_EN is defined.
REQ-021 SHALL, with RR_TIMEOUT_EN, count owned cycles (1 on the first grant cycle) and reset the count on every new grant.
REQ-022 SHALL, with RR_TIMEOUT_EN, when count == HOLD_MAX and another req bit is set, revoke the owner, hand off per REQ-013, and pulse preempt for that cycle. With a lone requester the count saturates and the grant is kept.
REQ-023 SHALL, without RR_TIMEOUT_EN, contain no counter, tie preempt to 0, and never revoke a grant.

Structure
REQ-024 SHALL place the state encoding (IDLE/OWNED), NUM_REQ = 4 and ID_W = 2 in shared package arb_pkg.
REQ-025 SHALL instantiate the existing decoder2_4 as its single sub-module for the gnt_id to gnt one-hot decode, gated by gnt_valid.

Verification
REQ-026 SHALL cover reset and single request: after reset, req = 4'b0100 -> gnt = 4'b0100, gnt_id = 2, one cycle after req is sampled.
REQ-027 SHALL cover round-robin: req = 4'b1111 held, each owner drops req for one cycle after 3 cycles -> grant order 0, 1, 2, 3, 0, with zero idle cycles between owners.
REQ-028 SHALL cover wrap and skip: ptr = 3, req = 4'b0010 -> gnt = 4'b0010, and gnt never shows two bits set.
REQ-029 SHALL cover reset mid-ownership: rst_n low while gnt = 4'b1000 -> gnt = 0 asynchronously; after release with req = 4'b1001 -> grant to requester 0.
REQ-030 SHALL cover the timeout build: with RR_TIMEOUT_EN and HOLD_MAX = 4, req = 4'b0011 held -> requester 0 owns 4 cycles, preempt pulses once, gnt = 4'b0010. Without the macro, requester 0 keeps the grant indefinitely and preempt stays 0.
